// File: rtl/mem_stage.sv
// Memory stage of the tartaruga pipeline: passes ALU results through and performs
// loads and stores over the req/gnt/rvalid data-memory handshake, stalling EXE meanwhile.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;

  typedef enum logic {
    ALU = 1'b0,
    MEM = 1'b1
  } alu_or_mem_e;

  typedef struct packed {
    logic [6:0] func7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rtype_t;

  typedef union packed {
    rtype_t rtype;
    bus32_t raw;
  } instr_word_t;

  typedef struct packed {
    instr_word_t instr;
    alu_or_mem_e alu_or_mem;
    logic        store_to_mem;
  } instr_t;

  typedef struct packed {
    instr_t instr;
    bus32_t result;
    bus32_t rs2;
    logic   branch_taken;
  } exe_to_mem_t;

  typedef struct packed {
    instr_t instr;
    bus32_t result;
    logic   branch_taken;
  } mem_to_wb_t;

endpackage

module mem_stage
  import tartaruga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  exe_to_mem_t exe_to_mem_i,
  input  logic        valid_i,
  output logic        ready_o,
  output mem_to_wb_t  mem_to_wb_o,
  output logic        valid_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  mem_to_wb_t  held_q, held_d;
  mem_to_wb_t  wb_q, wb_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic        in_store;
  logic        in_mem;
  logic [2:0]  in_f3;
  logic [2:0]  held_f3;
  logic [31:0] load_value;

  // Sizing depends only on func3[1:0]: 00 byte, 01 half, anything else word.
  function automatic logic [3:0] be_for(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_for(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] wd;
    case (f3[1:0])
      2'b00:   wd = {4{rs2[7:0]}};
      2'b01:   wd = {2{rs2[15:0]}};
      default: wd = rs2;
    endcase
    return wd;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] value;
    shifted = rdata >> {off, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'd0:    value = {{24{byte_v[7]}}, byte_v};
      3'd1:    value = {{16{half_v[15]}}, half_v};
      3'd4:    value = {24'd0, byte_v};
      3'd5:    value = {16'd0, half_v};
      default: value = rdata;
    endcase
    return value;
  endfunction

  assign in_store   = exe_to_mem_i.instr.store_to_mem;
  assign in_mem     = in_store || (exe_to_mem_i.instr.alu_or_mem == MEM);
  assign in_f3      = exe_to_mem_i.instr.instr.rtype.func3;
  assign held_f3    = held_q.instr.instr.rtype.func3;
  assign load_value = load_fmt(held_f3, held_q.result[1:0], dmem_rdata_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i && in_mem) state_d = REQ;
      REQ:     if (dmem_gnt_i) state_d = held_q.instr.store_to_mem ? IDLE : WAIT;
      WAIT:    if (dmem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    held_d  = held_q;
    wb_d    = wb_q;
    valid_d = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (in_mem) begin
            held_d.instr        = exe_to_mem_i.instr;
            held_d.result       = exe_to_mem_i.result;
            held_d.branch_taken = exe_to_mem_i.branch_taken;
            req_d   = 1'b1;
            we_d    = in_store;
            addr_d  = {exe_to_mem_i.result[31:2], 2'b00};
            be_d    = be_for(in_f3, exe_to_mem_i.result[1:0]);
            wdata_d = wdata_for(in_f3, exe_to_mem_i.rs2);
          end else begin
            wb_d.instr        = exe_to_mem_i.instr;
            wb_d.result       = exe_to_mem_i.result;
            wb_d.branch_taken = exe_to_mem_i.branch_taken;
            valid_d = 1'b1;
          end
        end
      end
      REQ: begin
        // Request fields stay frozen until the grant.
        if (dmem_gnt_i) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (held_q.instr.store_to_mem) begin
            wb_d    = held_q;
            valid_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          wb_d.instr        = held_q.instr;
          wb_d.result       = load_value;
          wb_d.branch_taken = held_q.branch_taken;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q  <= '0;
      wb_q    <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      held_q  <= held_d;
      wb_q    <= wb_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign ready_o      = (state_q == IDLE);
  assign mem_to_wb_o  = wb_q;
  assign valid_o      = valid_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

endmodule
